// File: rtl/pg_pkg.sv
// pg_pkg: state encoding and default timing constants for the power-gating controller
package pg_pkg;
    typedef logic [2:0] pg_state_t;
    localparam pg_state_t S_ACTIVE  = 3'd0;
    localparam pg_state_t S_SAVE    = 3'd1;
    localparam pg_state_t S_ISOLATE = 3'd2;
    localparam pg_state_t S_OFF     = 3'd3;
    localparam pg_state_t S_PWRUP   = 3'd4;
    localparam pg_state_t S_RESTORE = 3'd5;
    localparam pg_state_t S_DEISO   = 3'd6;
    localparam int unsigned DEF_CONFIRM_EPOCHS = 2;
    localparam int unsigned DEF_ISO_CYCLES     = 2;
    localparam int unsigned DEF_PWR_UP_CYCLES  = 8;
    localparam int unsigned DEF_MIN_SLEEP      = 16;
endpackage

// File: rtl/pg_timer.sv
// pg_timer: 8-bit loadable down-counter; done marks the last cycle of a timed interval
module pg_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] val,
    output logic       done
);
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= load ? val : (cnt != 8'd0 ? cnt - 8'd1 : cnt);
    assign done = cnt == 8'd1;
endmodule

// File: rtl/pg_controller.sv
// pg_controller: prediction-driven power-gating sequencer with retention and isolation
module pg_controller import pg_pkg::*; #(
    parameter int unsigned CONFIRM_EPOCHS = DEF_CONFIRM_EPOCHS,
    parameter int unsigned ISO_CYCLES     = DEF_ISO_CYCLES,
    parameter int unsigned PWR_UP_CYCLES  = DEF_PWR_UP_CYCLES,
    parameter int unsigned MIN_SLEEP      = DEF_MIN_SLEEP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       epoch_tick,
    input  logic       predict,
    input  logic       busy,
    input  logic       wake_req,
    output logic       clk_en,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       iso_en,
    output logic       pwr_en,
    output logic       ready,
    output logic       early_wake,
    output logic [7:0] early_cnt
);
    pg_state_t  st, nx;
    logic [3:0] conf;
    logic [7:0] res;
    logic       wake, hit, early, tload, tdone;
    assign wake  = busy | wake_req;
    assign hit   = epoch_tick & predict & ~busy & (conf + 4'd1 == 4'(CONFIRM_EPOCHS));
    assign early = (st == S_OFF) & wake & (res < 8'(MIN_SLEEP));
    assign tload = (st == S_SAVE && !wake) || (st == S_OFF && wake);
    always_comb begin
        nx = st;
        case (st)
            S_ACTIVE:  nx = hit ? S_SAVE : S_ACTIVE;
            S_SAVE:    nx = wake ? S_DEISO : S_ISOLATE;
            S_ISOLATE: nx = wake ? S_DEISO : (tdone ? S_OFF : S_ISOLATE);
            S_OFF:     nx = wake ? S_PWRUP : S_OFF;
            S_PWRUP:   nx = tdone ? S_RESTORE : S_PWRUP;
            S_RESTORE: nx = S_DEISO;
            default:   nx = S_ACTIVE;
        endcase
    end
    pg_timer u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tload),
        .val  (st == S_SAVE ? 8'(ISO_CYCLES) : 8'(PWR_UP_CYCLES)),
        .done (tdone)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_ACTIVE;
            conf       <= '0;
            res        <= '0;
            early_wake <= 1'b0;
            early_cnt  <= '0;
        end else begin
            st         <= nx;
            conf       <= (st != S_ACTIVE || busy || hit || (epoch_tick && !predict)) ? 4'd0 : (epoch_tick ? conf + 4'd1 : conf);
            res        <= st != S_OFF ? 8'd0 : (res == 8'hff ? res : res + 8'd1);
            early_wake <= early;
            early_cnt  <= (early && early_cnt != 8'hff) ? early_cnt + 8'd1 : early_cnt;
        end
    end
    // Isolation spans the whole unpowered window so pwr_en never drops while outputs float
    assign clk_en      = st == S_ACTIVE;
    assign ready       = st == S_ACTIVE;
    assign ret_save    = st == S_SAVE;
    assign ret_restore = st == S_RESTORE;
    assign pwr_en      = st != S_OFF;
    assign iso_en      = st == S_ISOLATE || st == S_OFF || st == S_PWRUP || st == S_RESTORE;
endmodule

// File: tb/tb_pg_controller.sv
// tb_pg_controller: table vectors plus hand sequences, checked through a scoreboard queue
module tb_pg_controller;
    logic clk = 1'b0, rst_n = 1'b0;
    logic epoch_tick = 1'b0, predict = 1'b0, busy = 1'b0, wake_req = 1'b0;
    logic clk_en, ret_save, ret_restore, iso_en, pwr_en, ready, early_wake;
    logic [7:0] early_cnt;

    pg_controller dut (
        .clk(clk), .rst_n(rst_n), .epoch_tick(epoch_tick), .predict(predict),
        .busy(busy), .wake_req(wake_req), .clk_en(clk_en), .ret_save(ret_save),
        .ret_restore(ret_restore), .iso_en(iso_en), .pwr_en(pwr_en), .ready(ready),
        .early_wake(early_wake), .early_cnt(early_cnt)
    );

    always #5 clk = ~clk;

    // {clk_en, ret_save, ret_restore, iso_en, pwr_en, ready, early_wake}
    localparam logic [6:0] ACT   = 7'b1000110;
    localparam logic [6:0] SAV   = 7'b0100100;
    localparam logic [6:0] ISO   = 7'b0001100;
    localparam logic [6:0] OFF   = 7'b0001000;
    localparam logic [6:0] PUP   = 7'b0001100;
    localparam logic [6:0] PUP_E = 7'b0001101;
    localparam logic [6:0] RST   = 7'b0011100;
    localparam logic [6:0] DEI   = 7'b0000100;

    typedef struct { logic [3:0] in; logic [6:0] exp; } vec_t;
    typedef struct { logic [6:0] o; logic [7:0] c; string n; } sb_t;

    sb_t        sbq[$];
    vec_t       tbl[13];
    int         errors = 0, checks = 0;
    logic [7:0] exp_cnt = 8'd0;

    function automatic logic [7:0] outs();
        return {1'b0, clk_en, ret_save, ret_restore, iso_en, pwr_en, ready, early_wake};
    endfunction

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b want %b", n, a, e);
        end
    endtask

    // inputs {epoch_tick, predict, busy, wake_req}; exp is the output vector after the sampling edge
    task automatic cyc(input logic [3:0] in, input logic [6:0] e, input string n);
        sb_t s;
        {epoch_tick, predict, busy, wake_req} = in;
        if (e[0] && exp_cnt != 8'hff) exp_cnt++;
        s.o = e; s.c = exp_cnt; s.n = n;
        sbq.push_back(s);
        @(posedge clk); #1;
        s = sbq.pop_front();
        chk(s.n, outs(), {1'b0, s.o});
        chk({s.n, "_cnt"}, early_cnt, s.c);
        checks++;
        if ((ret_save && ret_restore) || (!pwr_en && !iso_en)) begin
            errors++;
            $display("FAIL %s_inv: save=%b restore=%b pwr=%b iso=%b", s.n, ret_save, ret_restore, pwr_en, iso_en);
        end
    endtask

    task automatic go_off(input string n, input int k);
        cyc(4'b1100, ACT, {n, "_tick1"});
        cyc(4'b1100, SAV, {n, "_save"});
        cyc(4'b0000, ISO, {n, "_iso1"});
        cyc(4'b0000, ISO, {n, "_iso2"});
        cyc(4'b0000, OFF, {n, "_off"});
        for (int i = 0; i < k; i++) cyc(4'b0000, OFF, {n, "_offwait"});
    endtask

    task automatic wake_up(input logic [3:0] in, input logic early, input string n);
        cyc(in, early ? PUP_E : PUP, {n, "_wake"});
        for (int i = 1; i < 8; i++) cyc({2'b00, i == 2, i == 3}, PUP, {n, "_pwrup"});
        cyc(4'b0000, RST, {n, "_restore"});
        cyc(4'b0000, DEI, {n, "_deiso"});
        cyc(4'b0000, ACT, {n, "_ready"});
    endtask

    initial begin
        tbl[0]  = '{4'b1100, ACT};
        tbl[1]  = '{4'b0000, ACT};
        tbl[2]  = '{4'b1000, ACT};
        tbl[3]  = '{4'b1100, ACT};
        tbl[4]  = '{4'b0000, ACT};
        tbl[5]  = '{4'b1110, ACT};
        tbl[6]  = '{4'b1100, ACT};
        tbl[7]  = '{4'b0010, ACT};
        tbl[8]  = '{4'b1100, ACT};
        tbl[9]  = '{4'b1100, SAV};
        tbl[10] = '{4'b0000, ISO};
        tbl[11] = '{4'b0000, ISO};
        tbl[12] = '{4'b0000, OFF};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs(), {1'b0, ACT});
        chk("reset_cnt", early_cnt, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) cyc(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
        for (int i = 0; i < 40; i++) cyc(4'b0000, OFF, "off40");
        wake_up(4'b0001, 1'b0, "late");

        go_off("early5", 5);
        wake_up(4'b0010, 1'b1, "early5");
        go_off("res15", 15);
        wake_up(4'b0001, 1'b1, "res15");
        go_off("res16", 16);
        wake_up(4'b0001, 1'b0, "res16");

        cyc(4'b1100, ACT, "abiso_tick1");
        cyc(4'b1100, SAV, "abiso_save");
        cyc(4'b0000, ISO, "abiso_iso");
        cyc(4'b0010, DEI, "abiso_deiso");
        cyc(4'b0000, ACT, "abiso_active");
        cyc(4'b1100, ACT, "absav_tick1");
        cyc(4'b1100, SAV, "absav_save");
        cyc(4'b0001, DEI, "absav_deiso");
        cyc(4'b0000, ACT, "absav_active");

        for (int i = 0; i < 300; i++) begin
            go_off("sat", 0);
            wake_up(4'b0010, 1'b1, "sat");
        end
        chk("early_cnt_sat", early_cnt, 8'd255);

        go_off("rst", 0);
        cyc(4'b0001, PUP_E, "rst_wake");
        cyc(4'b0000, PUP, "rst_pwrup");
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 8'd0;
        chk("rst_async_outs", outs(), {1'b0, ACT});
        chk("rst_async_cnt", early_cnt, 8'd0);
        @(posedge clk); #1;
        chk("rst_hold_outs", outs(), {1'b0, ACT});
        #2 rst_n = 1'b1;
        cyc(4'b0000, ACT, "post_rst_idle");
        cyc(4'b1100, ACT, "post_rst_tick1");
        cyc(4'b1100, SAV, "post_rst_save");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pg_controller.md
PG_CONTROLLER -- requirements
Module: pg_controller

Interface
REQ-001 SHALL have parameter CONFIRM_EPOCHS, default 2: consecutive idle predictions required before power-down (range 1..15).
REQ-002 SHALL have parameter ISO_CYCLES, default 2: isolation settle cycles before power-off (range 1..255).
REQ-003 SHALL have parameter PWR_UP_CYCLES, default 8: rail settle cycles after power-on (range 1..255).
REQ-004 SHALL have parameter MIN_SLEEP, default 16: OFF residency (cycles) below which a wake counts as early (range 1..255).
REQ-005 SHALL have ports: clk  in  1  sole clock.
REQ-006 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 epoch_tick  in  1  one-cycle pulse; predict is valid in this cycle.
REQ-008 predict  in  1  perceptron output, 1 = idle epoch predicted.
REQ-009 busy  in  1  gated unit has pending work.
REQ-010 wake_req  in  1  external wake request.
REQ-011 clk_en  out  1  clock enable to gated unit.
REQ-012 ret_save  out  1  one-cycle retention save strobe.
REQ-013 ret_restore  out  1  one-cycle retention restore strobe.
REQ-014 iso_en  out  1  output isolation enable.
REQ-015 pwr_en  out  1  power switch enable.
REQ-016 ready  out  1  unit powered, de-isolated, clocked.
REQ-017 early_wake  out  1  one-cycle mispredict pulse, fed back to training logic.
REQ-018 early_cnt  out  8  saturating count of early wakes.

Function
REQ-019 SHALL implement states ACTIVE, SAVE, ISOLATE, OFF, PWRUP, RESTORE, DEISO; all outputs registered or decoded from registered state only.
REQ-020 Confidence counter (4 bit): +1 on epoch_tick&predict&!busy in ACTIVE; cleared on epoch_tick&!predict, on any busy cycle, and on leaving ACTIVE.
REQ-021 ACTIVE->SAVE on the edge where the counter reaches CONFIRM_EPOCHS; busy in that cycle takes priority (stay ACTIVE, clear).
REQ-022 SAVE: exactly 1 cycle, ret_save=1, clk_en=0, then ISOLATE.
REQ-023 ISOLATE: ISO_CYCLES cycles, iso_en=1, clk_en=0, then OFF.
REQ-024 SAVE or ISOLATE with busy|wake_req sampled: abort to DEISO (no power drop, no restore).
REQ-025 OFF: pwr_en=0, iso_en=1, clk_en=0; residency counter runs from 0, saturating at 255.
REQ-026 OFF->PWRUP on sampled busy|wake_req; if residency < MIN_SLEEP, early_wake=1 for that transition cycle and early_cnt increments (saturates at 255).
REQ-027 PWRUP: pwr_en=1, iso_en=1 for PWR_UP_CYCLES cycles; wake/busy inputs ignored; then RESTORE.
REQ-028 RESTORE: 1 cycle ret_restore=1, iso_en=1; then DEISO.
REQ-029 DEISO: 1 cycle iso_en=0, clk_en=0; then ACTIVE.
REQ-030 ACTIVE: clk_en=1, pwr_en=1, iso_en=0, ready=1; ready=0 in every other state.
REQ-031 Wake latency: ready rises PWR_UP_CYCLES+3 cycles after the wake-sampling edge.
REQ-032 ret_save and ret_restore SHALL never be high simultaneously; pwr_en=0 only while iso_en=1.

Reset
REQ-033 rst_n low SHALL immediately force ACTIVE, counters 0, early_cnt 0, clk_en=1, pwr_en=1, iso_en=0, ret_save=0, ret_restore=0, ready=1, early_wake=0, from any state.
REQ-034 Deassertion SHALL be synchronised to clk by the integrator; block samples no inputs in the reset cycle.

Structure
REQ-035 Package pg_pkg SHALL hold the state enum and default parameter constants.
REQ-036 One sub-module pg_timer (8-bit loadable down-counter with done flag) SHALL serve ISOLATE/PWRUP timing; residency counter stays inline.

Verification
REQ-037 Two epoch_ticks with predict=1, busy=0 -> SAVE next cycle, ret_save 1 cycle, iso_en high 2 cycles before pwr_en=0.
REQ-038 Epochs predict=1,0,1 -> counter clears, no SAVE; third qualifying epoch alone insufficient.
REQ-039 In OFF for 40 cycles, wake_req pulse -> pwr_en=1 next cycle, ret_restore after 8 cycles, ready 11 cycles after sample, early_wake=0.
REQ-040 busy after 5 cycles in OFF -> early_wake pulse, early_cnt 0->1; 300 such wakes -> early_cnt=255.
REQ-041 busy during ISOLATE -> DEISO then ACTIVE, pwr_en never 0, no ret_restore.
REQ-042 rst_n low during PWRUP -> outputs at reset values within same cycle, ACTIVE after release.
